// File: rtl/data_sync_mc_pkg.sv
// Shared constants and helpers for the multi-channel bus synchroniser.
package data_sync_pkg;

  localparam int EN_MODE_LEVEL  = 0;
  localparam int EN_MODE_TOGGLE = 1;

  // Bit offset of channel c inside a flat NUM_CH*width bus.
  function automatic int bus_offset(input int c, input int width);
    return c * width;
  endfunction

endpackage

// File: rtl/data_sync_mc_ch.sv
// One channel: enable synchroniser, edge detect, holding register,
// valid/ready handshake and sticky overrun flag.
module data_sync_ch
  import data_sync_pkg::*;
#(
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_STAGES = 2,
  parameter int EN_MODE    = EN_MODE_LEVEL
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] unsync_bus,
  input  logic                 bus_enable,
  input  logic                 sync_ready,
  input  logic                 ovr_clr,
  output logic [BUS_WIDTH-1:0] sync_bus,
  output logic                 sync_valid,
  output logic                 enable_pulse,
  output logic                 overrun
);

  logic [NUM_STAGES-1:0] sync_chain_reg;
  logic                  prev_reg;
  logic [BUS_WIDTH-1:0]  bus_reg;
  logic                  valid_reg;
  logic                  pulse_reg;
  logic                  overrun_reg;
  logic                  sync_en;
  logic                  event_det;

  assign sync_en = sync_chain_reg[NUM_STAGES-1];

  generate
    if (EN_MODE == EN_MODE_TOGGLE) begin : g_toggle
      assign event_det = sync_en ^ prev_reg;
    end else begin : g_level
      assign event_det = sync_en & ~prev_reg;
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_chain_reg <= '0;
      prev_reg       <= 1'b0;
      bus_reg        <= '0;
      valid_reg      <= 1'b0;
      pulse_reg      <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      sync_chain_reg <= {sync_chain_reg[NUM_STAGES-2:0], bus_enable};
      prev_reg       <= sync_en;
      pulse_reg      <= event_det;
      if (event_det) begin
        bus_reg <= unsync_bus;
      end
      // A new word always leaves the holder full; ready only drains it
      // when nothing new arrives in the same cycle.
      if (event_det) begin
        valid_reg <= 1'b1;
      end else if (sync_ready) begin
        valid_reg <= 1'b0;
      end
      // Set has priority over clear.
      if (event_det && valid_reg && !sync_ready) begin
        overrun_reg <= 1'b1;
      end else if (ovr_clr) begin
        overrun_reg <= 1'b0;
      end
    end
  end

  assign sync_bus     = bus_reg;
  assign sync_valid   = valid_reg;
  assign enable_pulse = pulse_reg;
  assign overrun      = overrun_reg;

endmodule

// File: rtl/data_sync_mc.sv
// Multi-channel bus synchroniser: NUM_CH independent channels carried
// into the CLK domain, each sliced out of the flat buses.
module data_sync_mc
  import data_sync_pkg::*;
#(
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_STAGES = 2,
  parameter int NUM_CH     = 2,
  parameter int EN_MODE    = EN_MODE_LEVEL
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_CH*BUS_WIDTH-1:0] unsync_bus,
  input  logic [NUM_CH-1:0]           bus_enable,
  input  logic [NUM_CH-1:0]           sync_ready,
  input  logic [NUM_CH-1:0]           ovr_clr,
  output logic [NUM_CH*BUS_WIDTH-1:0] sync_bus,
  output logic [NUM_CH-1:0]           sync_valid,
  output logic [NUM_CH-1:0]           enable_pulse,
  output logic [NUM_CH-1:0]           overrun
);

  generate
    if (NUM_STAGES < 2 || NUM_CH < 1) begin : g_param_check
      $fatal(1, "data_sync_mc: NUM_STAGES must be >= 2 and NUM_CH >= 1");
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      data_sync_ch #(
        .BUS_WIDTH (BUS_WIDTH),
        .NUM_STAGES(NUM_STAGES),
        .EN_MODE   (EN_MODE)
      ) u_ch (
        .CLK         (CLK),
        .RST         (RST),
        .unsync_bus  (unsync_bus[bus_offset(gi, BUS_WIDTH) +: BUS_WIDTH]),
        .bus_enable  (bus_enable[gi]),
        .sync_ready  (sync_ready[gi]),
        .ovr_clr     (ovr_clr[gi]),
        .sync_bus    (sync_bus[bus_offset(gi, BUS_WIDTH) +: BUS_WIDTH]),
        .sync_valid  (sync_valid[gi]),
        .enable_pulse(enable_pulse[gi]),
        .overrun     (overrun[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_data_sync_mc.sv
// Bench: a level-mode (2-stage) and a toggle-mode (3-stage) instance driven
// with directed then random stimulus against a sample-history model.
module tb_data_sync_mc;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  logic [15:0] ubus [2];
  logic [1:0]  en   [2];
  logic [1:0]  rdy  [2];
  logic [1:0]  clr  [2];
  logic [15:0] sbus [2];
  logic [1:0]  valid[2];
  logic [1:0]  pulse[2];
  logic [1:0]  ovr  [2];

  data_sync_mc #(.BUS_WIDTH(8), .NUM_STAGES(2), .NUM_CH(2), .EN_MODE(0)) u_lvl (
    .CLK(CLK), .RST(RST), .unsync_bus(ubus[0]), .bus_enable(en[0]),
    .sync_ready(rdy[0]), .ovr_clr(clr[0]), .sync_bus(sbus[0]),
    .sync_valid(valid[0]), .enable_pulse(pulse[0]), .overrun(ovr[0]));

  data_sync_mc #(.BUS_WIDTH(8), .NUM_STAGES(3), .NUM_CH(2), .EN_MODE(1)) u_tgl (
    .CLK(CLK), .RST(RST), .unsync_bus(ubus[1]), .bus_enable(en[1]),
    .sync_ready(rdy[1]), .ovr_clr(clr[1]), .sync_bus(sbus[1]),
    .sync_valid(valid[1]), .enable_pulse(pulse[1]), .overrun(ovr[1]));

  // Reference model: hist holds bus_enable samples, bit 0 = latest edge.
  logic [7:0] hist   [2][2];
  logic [7:0] m_bus  [2][2];
  logic       m_valid[2][2];
  logic       m_pulse[2][2];
  logic       m_ovr  [2][2];

  int vectors = 0;
  int miscompares = 0;

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) begin
        hist[d][c] = '0; m_bus[d][c] = '0; m_valid[d][c] = 1'b0;
        m_pulse[d][c] = 1'b0; m_ovr[d][c] = 1'b0;
      end
  endtask

  task automatic model_edge();
    int  ns;
    logic s_new, s_old, ev;
    if (!RST) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) begin
        ns = (d == 0) ? 2 : 3;
        hist[d][c] = {hist[d][c][6:0], en[d][c]};
        // Synchronised level seen at this edge is the sample ns edges ago.
        s_new = hist[d][c][ns];
        s_old = hist[d][c][ns+1];
        ev = (d == 1) ? (s_new != s_old) : (s_new && !s_old);
        if (ev && m_valid[d][c] && !rdy[d][c]) m_ovr[d][c] = 1'b1;
        else if (clr[d][c]) m_ovr[d][c] = 1'b0;
        if (ev) begin
          m_bus[d][c] = ubus[d][c*8 +: 8];
          m_valid[d][c] = 1'b1;
        end else if (rdy[d][c]) begin
          m_valid[d][c] = 1'b0;
        end
        m_pulse[d][c] = ev;
      end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_bus", d), sbus[d], {m_bus[d][1], m_bus[d][0]});
      chk($sformatf("d%0d_valid", d), {14'd0, valid[d]}, {14'd0, m_valid[d][1], m_valid[d][0]});
      chk($sformatf("d%0d_pulse", d), {14'd0, pulse[d]}, {14'd0, m_pulse[d][1], m_pulse[d][0]});
      chk($sformatf("d%0d_ovr", d), {14'd0, ovr[d]}, {14'd0, m_ovr[d][1], m_ovr[d][0]});
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      model_edge();
      #1;
      check_all();
    end
  endtask

  int pulses;

  initial begin
    for (int d = 0; d < 2; d++) begin
      ubus[d] = '0; en[d] = '0; rdy[d] = '0; clr[d] = '0;
    end
    model_reset();
    #1;
    check_all();
    step(2);
    RST = 1'b1;
    step(1);

    // Level latency: enable sampled at edge 1, capture at edge 3.
    ubus[0] = 16'h00A5; en[0] = 2'b01;
    step(3);
    chk("lat_pulse", {15'd0, pulse[0][0]}, 16'd1);
    chk("lat_data", {8'd0, sbus[0][7:0]}, 16'h00A5);
    chk("lat_ch1_idle", {14'd0, valid[0][1], pulse[0][1]}, 16'd0);
    step(1);
    chk("pulse_width", {15'd0, pulse[0][0]}, 16'd0);

    rdy[0] = 2'b01; step(1); rdy[0] = 2'b00; step(1);
    chk("hs_valid", {15'd0, valid[0][0]}, 16'd0);
    chk("hs_bus_kept", {8'd0, sbus[0][7:0]}, 16'h00A5);

    // Two unconsumed words -> overrun.
    en[0] = 2'b00; step(4); ubus[0] = 16'h0011; en[0] = 2'b01; step(4);
    en[0] = 2'b00; step(4); ubus[0] = 16'h0022; en[0] = 2'b01; step(4);
    chk("ovr_set", {15'd0, ovr[0][0]}, 16'd1);
    chk("ovr_data", {8'd0, sbus[0][7:0]}, 16'h0022);
    clr[0] = 2'b01; step(1); clr[0] = 2'b00; step(1);
    chk("ovr_clr", {15'd0, ovr[0][0]}, 16'd0);

    // Clear coincident with a third overwrite: set wins.
    en[0] = 2'b00; step(4); ubus[0] = 16'h0044; en[0] = 2'b01;
    step(2); clr[0] = 2'b01; step(1); clr[0] = 2'b00;
    chk("ovr_set_wins", {15'd0, ovr[0][0]}, 16'd1);
    clr[0] = 2'b01; step(1); clr[0] = 2'b00;

    // Event with ready while full: new data, no overrun.
    en[0] = 2'b00; step(4); ubus[0] = 16'h0033; en[0] = 2'b01;
    step(2); rdy[0] = 2'b01; step(1); rdy[0] = 2'b00;
    chk("evrdy_data", {8'd0, sbus[0][7:0]}, 16'h0033);
    chk("evrdy_flags", {14'd0, valid[0][0], ovr[0][0]}, 16'b10);

    // Toggle mode, 3 stages: 4-edge latency per toggle.
    ubus[1] = 16'h005A; en[1] = 2'b01; step(4);
    chk("tgl1_pulse", {15'd0, pulse[1][0]}, 16'd1);
    chk("tgl1_data", {8'd0, sbus[1][7:0]}, 16'h005A);
    step(2); ubus[1] = 16'h00C3; en[1] = 2'b00; step(4);
    chk("tgl2_pulse", {15'd0, pulse[1][0]}, 16'd1);
    chk("tgl2_data", {8'd0, sbus[1][7:0]}, 16'h00C3);

    // Reset between capture and ready, enable left high.
    en[0] = 2'b00; step(4); ubus[0] = 16'h0077; en[0] = 2'b01; step(3);
    RST = 1'b0; model_reset(); #1;
    check_all();
    step(2); RST = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      pulses += int'(pulse[0][0]);
    end
    chk("rst_one_event", pulses[15:0], 16'd1);

    // Randomised phase on all channels of both instances.
    for (int i = 0; i < 400; i++) begin
      for (int d = 0; d < 2; d++) begin
        ubus[d] = 16'($urandom);
        for (int c = 0; c < 2; c++) begin
          if ($urandom_range(0, 3) == 0) en[d][c] = ~en[d][c];
          rdy[d][c] = ($urandom_range(0, 2) == 0);
          clr[d][c] = ($urandom_range(0, 7) == 0);
        end
      end
      if (i == 200) begin
        RST = 1'b0; model_reset(); #1; check_all(); RST = 1'b1;
      end
      step(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
